// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a 5-row x 4-column button matrix and debounces the result. One row is
// driven low at a time; after a settling interval its four columns are
// captured into a full-matrix snapshot. Once a snapshot has been seen
// identically for DEBOUNCE_SCANS consecutive scans it is committed to
// key_state, and the changed keys are reported as one-cycle pulses.
//
// Key index = row*4 + col (row 0..4 on btn_x, col 0..3 on btn_y).
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn_x[4:0]     row drive, active-low, exactly one bit low at all times
//   btn_y[3:0]     column sense, pulled up; low = key closed on driven row
//   key_state[19:0]     debounced level per key, 1 = pressed
//   press_pulse[19:0]   one-cycle pulse on a debounced 0->1 transition
//   release_pulse[19:0] one-cycle pulse on a debounced 1->0 transition
//   key_any        OR of key_state
//   key_code[4:0]  lowest index set in key_state, 0 when none
//   scan_done      one-cycle pulse in the evaluation cycle of each scan
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  btn_x,
  input  logic [3:0]  btn_y,
  output logic [19:0] key_state,
  output logic [19:0] press_pulse,
  output logic [19:0] release_pulse,
  output logic        key_any,
  output logic [4:0]  key_code,
  output logic        scan_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_MAX     = STB_W'(DEBOUNCE_SCANS);
  localparam logic [2:0]       LAST_ROW    = 3'd4;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_next;
  logic [2:0]       row, row_next;

  logic [19:0]      snapshot;
  logic [19:0]      prev_snapshot;
  logic [STB_W-1:0] stable_cnt, stable_cnt_next;
  logic             commit;

  // ---------------------------------------------------------------------------
  // Scan sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      row        <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      row        <= row_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan sequencer: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    row_next        = row;
    unique case (state)
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next      = ST_SAMPLE;
          settle_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        settle_cnt_next = '0;
        if (row == LAST_ROW) begin
          state_next = ST_EVAL;
          row_next   = '0;
        end else begin
          state_next = ST_SETTLE;
          row_next   = row + 1'b1;
        end
      end
      ST_EVAL: begin
        state_next      = ST_SETTLE;
        settle_cnt_next = '0;
      end
      default: begin
        state_next      = ST_SETTLE;
        settle_cnt_next = '0;
        row_next        = '0;
      end
    endcase
  end

  // Row drive follows the row register directly; it is glitch-free because
  // the register only changes on the clock edge ending a SAMPLE cycle.
  assign btn_x     = ~(5'b00001 << row);
  assign scan_done = (state == ST_EVAL);

  // ---------------------------------------------------------------------------
  // Debounce evaluation
  // ---------------------------------------------------------------------------
  // A scan that differs from the previous one restarts the stability count,
  // so any bounce shorter than a scan merely postpones the commit.
  always_comb begin
    stable_cnt_next = STB_W'(1);
    if (snapshot == prev_snapshot) begin
      stable_cnt_next = (stable_cnt == STB_MAX) ? STB_MAX : stable_cnt + 1'b1;
    end
  end

  assign commit = (state == ST_EVAL) && (stable_cnt_next == STB_MAX) &&
                  (snapshot != key_state);

  // NOTE: the snapshot registers are reset along with everything else so a
  // reset mid-scan cannot leak a partial capture into the next evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot      <= '0;
      prev_snapshot <= '0;
      stable_cnt    <= '0;
      key_state     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (state == ST_SAMPLE) begin
        snapshot[int'(row) * 4 +: 4] <= ~btn_y;
      end
      if (state == ST_EVAL) begin
        stable_cnt    <= stable_cnt_next;
        prev_snapshot <= snapshot;
        if (commit) begin
          key_state     <= snapshot;
          press_pulse   <= snapshot & ~key_state;
          release_pulse <= ~snapshot & key_state;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Summary outputs
  // ---------------------------------------------------------------------------
  assign key_any = |key_state;

  // Scanning from the top down leaves the lowest set index as the final value.
  always_comb begin
    key_code = '0;
    for (int i = 19; i >= 0; i--) begin
      if (key_state[i]) key_code = 5'(i);
    end
  end

endmodule
